// File: rtl/exe_unit_seq.sv
// Command sequencer for exe_unit_w1: FIFO-buffered host commands, one outstanding op, fixed-latency capture.
// Optional error-status counter built only when EXE_SEQ_ERRCNT_EN is defined.
module exe_unit_seq #(
  parameter int M     = 4,
  parameter int N     = 2,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [N-1:0] i_cmd_oper,
  input  logic [M-1:0] i_cmd_argA,
  input  logic [M-1:0] i_cmd_argB,
  output logic [N-1:0] o_oper,
  output logic [M-1:0] o_argA,
  output logic [M-1:0] o_argB,
  output logic         o_issue,
  input  logic [M-1:0] i_result,
  input  logic [1:0]   i_status,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [M-1:0] o_rsp_result,
  output logic [1:0]   o_rsp_status,
  output logic         o_busy,
  output logic [7:0]   o_err_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [LW-1:0] WAIT_INIT = LW'(LAT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

  typedef struct packed {
    logic [N-1:0] oper;
    logic [M-1:0] arg_a;
    logic [M-1:0] arg_b;
  } cmd_t;

  state_e         state_q, state_d;
  cmd_t           mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           cmd_ready_q;
  logic [LW-1:0]  wait_cnt_q;
  cmd_t           issued_q;
  logic [M-1:0]   rsp_result_q;
  logic [1:0]     rsp_status_q;
  logic           push, pop, capture;

  // Ready comes from a register, so a full FIFO refuses a push even when it pops that cycle.
  assign push    = i_cmd_valid && cmd_ready_q;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign capture = (state_q == S_WAIT) && (wait_cnt_q == '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      cmd_ready_q <= (count_d != FULL_CNT);
    end
  end

  // NOTE: storage array is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= '{oper: i_cmd_oper, arg_a: i_cmd_argA, arg_b: i_cmd_argB};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_cnt_q == '0) state_d = S_HOLD;
      S_HOLD:  if (i_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_issue     = 1'b0;
    o_rsp_valid = 1'b0;
    unique case (state_q)
      S_ISSUE: o_issue     = 1'b1;
      S_HOLD:  o_rsp_valid = 1'b1;
      default: ;
    endcase
    o_busy = (state_q != S_IDLE) || (count_q != '0);
  end

  // Operands load at the ISSUE-entry edge and then hold until the next issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      issued_q     <= '0;
      wait_cnt_q   <= '0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
    end else begin
      if (pop) issued_q <= mem_q[rd_ptr_q];
      if (state_q == S_ISSUE)
        wait_cnt_q <= WAIT_INIT;
      else if (state_q == S_WAIT && wait_cnt_q != '0)
        wait_cnt_q <= wait_cnt_q - 1'b1;
      if (capture) begin
        rsp_result_q <= i_result;
        rsp_status_q <= i_status;
      end
    end
  end

  assign o_cmd_ready  = cmd_ready_q;
  assign o_oper       = issued_q.oper;
  assign o_argA       = issued_q.arg_a;
  assign o_argB       = issued_q.arg_b;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_status = rsp_status_q;

`ifdef EXE_SEQ_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      err_cnt_q <= '0;
    else if (capture && i_status != 2'b00 && err_cnt_q != 8'hFF)
      err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_exe_unit_seq.sv
// Directed bench for exe_unit_seq: LAT=1 instance for most scenarios, LAT=3 instance for latency.
// The exe unit stand-in returns argA+argB and status oper^2'b01.
module tb_exe_unit_seq;

`ifdef EXE_SEQ_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd_oper;
  logic [3:0] cmd_a, cmd_b;

  logic       cmd_valid, cmd_ready, issue, rsp_valid, rsp_ready, busy;
  logic [1:0] oper, status, rsp_status;
  logic [3:0] arg_a, arg_b, result, rsp_result;
  logic [7:0] err_cnt;

  logic       cmd_valid3, cmd_ready3, issue3, rsp_valid3, rsp_ready3, busy3;
  logic [1:0] oper3, status3, rsp_status3;
  logic [3:0] arg_a3, arg_b3, result3, rsp_result3;
  logic [7:0] err_cnt3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign result  = arg_a + arg_b;
  assign status  = oper ^ 2'b01;
  assign result3 = arg_a3 + arg_b3;
  assign status3 = oper3 ^ 2'b01;

  exe_unit_seq #(.M(4), .N(2), .DEPTH(4), .LAT(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_oper(cmd_oper), .i_cmd_argA(cmd_a), .i_cmd_argB(cmd_b),
    .o_oper(oper), .o_argA(arg_a), .o_argB(arg_b), .o_issue(issue),
    .i_result(result), .i_status(status),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_status(rsp_status),
    .o_busy(busy), .o_err_cnt(err_cnt)
  );

  exe_unit_seq #(.M(4), .N(2), .DEPTH(4), .LAT(3)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid3), .o_cmd_ready(cmd_ready3),
    .i_cmd_oper(cmd_oper), .i_cmd_argA(cmd_a), .i_cmd_argB(cmd_b),
    .o_oper(oper3), .o_argA(arg_a3), .o_argB(arg_b3), .o_issue(issue3),
    .i_result(result3), .i_status(status3),
    .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3),
    .o_rsp_result(rsp_result3), .o_rsp_status(rsp_status3),
    .o_busy(busy3), .o_err_cnt(err_cnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (busy && guard < 400) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: busy=%b after %0d cycles, need 0", name, busy, guard);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    cmd_oper = '0; cmd_a = '0; cmd_b = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({cmd_ready, issue, rsp_valid, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctl: ready/issue/rsp_valid/busy=%b need 1000", {cmd_ready, issue, rsp_valid, busy});
    end
    n_cmp++;
    if ({oper, arg_a, arg_b, rsp_result, rsp_status, err_cnt} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h need 0", {oper, arg_a, arg_b, rsp_result, rsp_status, err_cnt});
    end
    n_cmp++;
    if ({cmd_ready3, issue3, rsp_valid3, busy3} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_lat3: ready/issue/rsp_valid/busy=%b need 1000", {cmd_ready3, issue3, rsp_valid3, busy3});
    end
  endtask

  task automatic test_single();
    int issues = 0;
    cmd_oper = 2'b01; cmd_a = 4'hF; cmd_b = 4'hD; cmd_valid = 1'b1;
    tick();                                    // E0: accepted
    cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      issues += int'(issue);
      if (c == 1) begin
        n_cmp++;
        if ({issue, oper, arg_a, arg_b} !== {1'b1, 2'b01, 4'hF, 4'hD}) begin
          n_fail++;
          $display("FAIL single_issue: issue/oper/A/B=%b/%b/%h/%h need 1/01/f/d", issue, oper, arg_a, arg_b);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early: rsp_valid=%b two cycles after push, need 0", rsp_valid);
        end
      end
      if (c >= 3) begin
        n_cmp++;
        if ({rsp_valid, rsp_result, rsp_status} !== {1'b1, 4'hC, 2'b00}) begin
          n_fail++;
          $display("FAIL single_rsp c%0d: valid/result/status=%b/%h/%b need 1/c/00", c, rsp_valid, rsp_result, rsp_status);
        end
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if ({issues[3:0], rsp_valid, busy} !== {4'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_done: issues=%0d rsp_valid=%b busy=%b need 1/0/0", issues, rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e_op [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    logic [3:0] e_a  [5] = '{4'h1, 4'h4, 4'h7, 4'h9, 4'hE};
    logic [3:0] e_b  [5] = '{4'h2, 4'h5, 4'h8, 4'h9, 4'h3};
    logic [3:0] e_r  [5] = '{4'h3, 4'h9, 4'hF, 4'h2, 4'h1};
    logic [1:0] e_s  [5] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b00};
    int  got = 0;
    int  guard = 0;
    bit  ready_seen = 1'b0;
    bit  ok_ready = 1'b1;
    rsp_ready = 1'b0;
    cmd_oper = e_op[0]; cmd_a = e_a[0]; cmd_b = e_b[0]; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    while (!rsp_valid && guard < 20) begin tick(); guard++; end
    for (int i = 1; i < 5; i++) begin
      if (cmd_ready !== 1'b1) ok_ready = 1'b0;
      cmd_oper = e_op[i]; cmd_a = e_a[i]; cmd_b = e_b[i]; cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if ({ok_ready, cmd_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_full: ready during fill=%b after 4th push=%b, need 1/0", ok_ready, cmd_ready);
    end
    cmd_oper = 2'b10; cmd_a = 4'h6; cmd_b = 4'h6; cmd_valid = 1'b1;
    tick(); tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_status} !== {1'b0, 1'b1, 4'h3, 2'b01}) begin
      n_fail++;
      $display("FAIL b2b_hold: ready/valid/result/status=%b/%b/%h/%b need 0/1/3/01",
               cmd_ready, rsp_valid, rsp_result, rsp_status);
    end
    rsp_ready = 1'b1;
    guard = 0;
    while (got < 5 && guard < 60) begin
      if (issue && !ready_seen) begin
        ready_seen = 1'b1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_back: cmd_ready=%b after first pop, need 1", cmd_ready);
        end
      end
      if (rsp_valid) begin
        n_cmp++;
        if ({rsp_result, rsp_status} !== {e_r[got], e_s[got]}) begin
          n_fail++;
          $display("FAIL b2b_rsp%0d: result/status=%h/%b need %h/%b", got, rsp_result, rsp_status, e_r[got], e_s[got]);
        end
        got++;
      end
      tick();
      guard++;
    end
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) got++;
      tick();
    end
    rsp_ready = 1'b0;
    n_cmp++;
    if ({got[3:0], busy} !== {4'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_count: responses=%0d busy=%b need 5/0", got, busy);
    end
  endtask

  task automatic test_lat3();
    int guard = 0;
    bit stable = 1'b1;
    rsp_ready3 = 1'b0;
    cmd_oper = 2'b10; cmd_a = 4'h3; cmd_b = 4'h4; cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    while (!issue3 && guard < 10) begin tick(); guard++; end
    n_cmp++;
    if ({issue3, guard[3:0]} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL lat3_issue: issue=%b after %0d cycles, need 1 after 1", issue3, guard);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      if ({rsp_valid3, oper3, arg_a3, arg_b3} !== {1'b0, 2'b10, 4'h3, 4'h4}) stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL lat3_window: early response or operand change, stable=%b need 1", stable);
    end
    tick();
    n_cmp++;
    if ({rsp_valid3, rsp_result3, rsp_status3, oper3, arg_a3} !== {1'b1, 4'h7, 2'b11, 2'b10, 4'h3}) begin
      n_fail++;
      $display("FAIL lat3_capture: valid/result/status=%b/%h/%b need 1/7/11", rsp_valid3, rsp_result3, rsp_status3);
    end
    rsp_ready3 = 1'b1;
    tick();
    rsp_ready3 = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int seen = 0;
    logic [1:0] ops [3] = '{2'b11, 2'b10, 2'b01};
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_oper = ops[i]; cmd_a = 4'(i + 5); cmd_b = 4'h1; cmd_valid = 1'b1;
      tick();
    end
    n_cmp++;
    if ({issue, rsp_valid, busy, oper, arg_a} !== {1'b0, 1'b0, 1'b1, 2'b11, 4'h5}) begin
      n_fail++;
      $display("FAIL rstw_pre: issue/valid/busy/oper/A=%b/%b/%b/%b/%h need 0/0/1/11/5",
               issue, rsp_valid, busy, oper, arg_a);
    end
    rst = 1'b1; rsp_ready = 1'b1; cmd_oper = 2'b10; cmd_valid = 1'b1;
    tick();
    n_cmp++;
    if ({cmd_ready, issue, rsp_valid, busy, oper, arg_a, arg_b, rsp_result, rsp_status, err_cnt} !==
        {1'b1, 27'h0}) begin
      n_fail++;
      $display("FAIL rstw_outputs: ready=%b issue=%b valid=%b busy=%b data=%h need 1/0/0/0/0", cmd_ready, issue,
               rsp_valid, busy, {oper, arg_a, arg_b, rsp_result, rsp_status, err_cnt});
    end
    rst = 1'b0; cmd_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (issue || rsp_valid || busy) seen++;
    end
    rsp_ready = 1'b0;
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL rstw_quiet: %0d active cycles after reset, need 0", seen);
    end
  endtask

  task automatic test_err_cnt();
    logic [1:0] ops [3] = '{2'b11, 2'b01, 2'b10};
    int pushed = 0;
    int guard = 0;
    bit rdy;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_oper = ops[i]; cmd_a = 4'h2; cmd_b = 4'h3; cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    wait_idle("err_three_idle");
    n_cmp++;
    if (err_cnt !== (ERR_EN ? 8'd2 : 8'd0)) begin
      n_fail++;
      $display("FAIL err_three: err_cnt=%0d need %0d", err_cnt, ERR_EN ? 2 : 0);
    end
    cmd_oper = 2'b00;
    while (pushed < 300 && guard < 5000) begin
      cmd_valid = 1'b1;
      rdy = cmd_ready;
      tick();
      if (rdy) pushed++;
      guard++;
    end
    cmd_valid = 1'b0;
    wait_idle("err_sat_idle");
    n_cmp++;
    if ({pushed[8:0], err_cnt} !== {9'd300, (ERR_EN ? 8'hFF : 8'h00)}) begin
      n_fail++;
      $display("FAIL err_sat: pushed=%0d err_cnt=%h need 300/%h", pushed, err_cnt, ERR_EN ? 8'hFF : 8'h00);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lat3();
    test_reset_mid_wait();
    test_err_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
